sys_master_arbiter: RTL and testbench
=====================================

Name: sys_master_arbiter

Overview:
- Shares the single system AXI4 master port (the one feeding the main crossbar) between two upstream masters, e.g. the JTAG2AXI/XDMA debug master (s0) and a second master such as a DMA engine (s1).
- Write and read channels are arbitrated independently, each with a round-robin FSM.
- A grant is held for a whole transaction: AW through B handshake for writes, AR through the RLAST handshake for reads.
- One outstanding transaction per direction, so IDs pass through unchanged.

Parameters:
- ADDR_WIDTH, 32, AXI address width (AXI_ADDR_WIDTH in uninasoc_pkg).
- DATA_WIDTH, 32, AXI data width.
- ID_WIDTH, 2, AXI ID width; identical on all three ports.

Ports:
- clk_i  in  1  SoC clock (soc_clk_o domain).
- rst_ni  in  1  asynchronous active-low reset.
- s0_axi_*  slave bundle  full AXI4 (AW, W, B, AR, R incl. id/len/size/burst/lock/cache/prot/qos)  upstream master 0.
- s1_axi_*  slave bundle  full AXI4, same widths  upstream master 1.
- m_axi_*  master bundle  full AXI4, same widths  to the crossbar.
- wr_grant_o  out  2  one-hot current write owner; 0 when idle.
- rd_grant_o  out  2  one-hot current read owner; 0 when idle.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All FSMs go to IDLE. Both round-robin pointers are set to last=1, so s0 wins the first tie.
  - All m_axi valid/ready outputs are 0. All s*_axi ready and response-valid outputs are 0. Grant outputs are 0.
- Write FSM: IDLE -> AW -> W -> B -> IDLE.
  - IDLE, arbitration: requests are s0_awvalid and s1_awvalid. Exactly one request: grant it. Both requests: grant the master other than last. Grant is registered; AW is forwarded the cycle after entry, so latency is one cycle from awvalid to m_awvalid. `last` is updated on grant.
  - AW: granted s-AW is wired combinationally to m-AW (valid, ready and payload). On the m_awvalid & m_awready handshake, go to W.
  - W: granted W is wired to m-W. On a handshake with wlast=1, go to B.
  - B: m-B is routed to the granted master only. On the bvalid & bready handshake, go to IDLE and clear the grant.
  - A master may present W before AW. Its W is stalled (wready=0) until it owns the write channel and the FSM is in the W state.
- Read FSM: IDLE -> AR -> R -> IDLE, with the same arbitration rule and its own `last` pointer.
  - AR forwarded once the FSM is in AR (one cycle after arvalid in IDLE); go to R on the AR handshake.
  - R routed to the granted master; go to IDLE on a handshake with rlast=1.
- Non-granted masters see:
  - awready, wready, arready = 0;
  - bvalid, rvalid = 0;
  - bresp, rresp, rdata, bid, rid driven 0.
- m_axi payload while no grant: all zeros, valid=0. m_bready and m_rready are 0 outside the B and R states.
- Read and write channels are fully independent: s0 may own read while s1 owns write, and vice versa.
- Request dropped in IDLE before grant: AXI forbids a master deasserting valid before its handshake. Behaviour in that case is undefined; an assertion in the bench flags it.
- Back-to-back: a master that still requests in IDLE right after its own transaction loses to a pending other master. If it is the only requester it is granted again; a full write costs minimum 1 + AW + W beats + B cycles.
- Reset mid-transaction: FSM returns to IDLE immediately and the grant clears. Upstream and downstream are reset by the same rst_ni, so no drain is performed.

Optional Feature:
- Macro: SYS_MASTER_ARBITER_STATS_EN.
- When defined:
  - Adds ports wr_grant_cnt_o (out, 2x32) and rd_grant_cnt_o (out, 2x32).
  - Per-master grant counters increment by 1 on each IDLE->AW or IDLE->AR grant, and saturate at 32'hFFFF_FFFF.
  - Counters reset to 0 on rst_ni.
- When undefined: the ports and counters do not exist, and arbitration is identical.

Test Plan:
- Single-master write: s0 AW addr 0x1000_0000, len=0, W data 0xDEADBEEF, strb 0xF; slave returns bresp OKAY. Required: m_awvalid one cycle after s0_awvalid; wr_grant_o=01 from AW through B; s0 receives bresp=0; s1 sees bvalid=0 throughout.
- Simultaneous writes after reset: s0 and s1 assert awvalid in the same cycle, each len=3. Required: s0 granted first, all 4 beats end with wlast; then s1 granted. Order on m-AW is s0,s1.
- Fairness: both masters continuously request 6 reads of len=0. Required: m-AR grant sequence alternates s0,s1,s0,s1,s0,s1. rd_grant_o is never 11.
- Concurrent directions: s0 issues a read burst (len=7) while s1 issues a write (len=1). Required: rd_grant_o=01 and wr_grant_o=10 simultaneously. Both complete with correct rid and bid, and rlast on beat 8.
- Early W: s1 drives wvalid 3 cycles before awvalid while s0 owns the write channel. Required: s1_wready=0 until s1 is granted and in the W state; no s1 beat appears on m-W early.
- Reset mid-burst: assert rst_ni=0 during beat 2 of a len=3 write. Required: all valids, readies and grants are 0 in the same cycle (asynchronous). After release, an s0/s1 tie grants s0. With SYS_MASTER_ARBITER_STATS_EN defined, counters read 0.

Source files
------------

// File: rtl/sys_master_arbiter.sv
// sys_master_arbiter
// Shares one AXI4 master port (m_axi_*) between two upstream masters
// (s0_axi_*, s1_axi_*). Write and read channels each have their own
// round-robin FSM, and a grant is held for a whole transaction:
//   write: IDLE -> AW -> W -> B -> IDLE
//   read : IDLE -> AR -> R -> IDLE
// Only one transaction is outstanding per direction, so IDs pass through unchanged.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   s0_axi_*, s1_axi_*       full AXI4 slave bundles (upstream masters)
//   m_axi_*                  full AXI4 master bundle (to the crossbar)
//   wr_grant_o, rd_grant_o   one-hot current owner, 2'b00 when idle
// Optional feature, macro SYS_MASTER_ARBITER_STATS_EN:
//   wr_grant_cnt_o, rd_grant_cnt_o  saturating per-master grant counters
module sys_master_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    // upstream master 0
    input  logic [ID_WIDTH-1:0] s0_axi_awid, input logic [ADDR_WIDTH-1:0] s0_axi_awaddr, input logic [7:0] s0_axi_awlen,
    input  logic [2:0] s0_axi_awsize, input logic [1:0] s0_axi_awburst, input logic s0_axi_awlock,
    input  logic [3:0] s0_axi_awcache, input logic [2:0] s0_axi_awprot, input logic [3:0] s0_axi_awqos,
    input  logic s0_axi_awvalid, output logic s0_axi_awready,
    input  logic [DATA_WIDTH-1:0] s0_axi_wdata, input logic [DATA_WIDTH/8-1:0] s0_axi_wstrb, input logic s0_axi_wlast,
    input  logic s0_axi_wvalid, output logic s0_axi_wready,
    output logic [ID_WIDTH-1:0] s0_axi_bid, output logic [1:0] s0_axi_bresp, output logic s0_axi_bvalid, input logic s0_axi_bready,
    input  logic [ID_WIDTH-1:0] s0_axi_arid, input logic [ADDR_WIDTH-1:0] s0_axi_araddr, input logic [7:0] s0_axi_arlen,
    input  logic [2:0] s0_axi_arsize, input logic [1:0] s0_axi_arburst, input logic s0_axi_arlock,
    input  logic [3:0] s0_axi_arcache, input logic [2:0] s0_axi_arprot, input logic [3:0] s0_axi_arqos,
    input  logic s0_axi_arvalid, output logic s0_axi_arready,
    output logic [ID_WIDTH-1:0] s0_axi_rid, output logic [DATA_WIDTH-1:0] s0_axi_rdata, output logic [1:0] s0_axi_rresp,
    output logic s0_axi_rlast, output logic s0_axi_rvalid, input logic s0_axi_rready,
    // upstream master 1
    input  logic [ID_WIDTH-1:0] s1_axi_awid, input logic [ADDR_WIDTH-1:0] s1_axi_awaddr, input logic [7:0] s1_axi_awlen,
    input  logic [2:0] s1_axi_awsize, input logic [1:0] s1_axi_awburst, input logic s1_axi_awlock,
    input  logic [3:0] s1_axi_awcache, input logic [2:0] s1_axi_awprot, input logic [3:0] s1_axi_awqos,
    input  logic s1_axi_awvalid, output logic s1_axi_awready,
    input  logic [DATA_WIDTH-1:0] s1_axi_wdata, input logic [DATA_WIDTH/8-1:0] s1_axi_wstrb, input logic s1_axi_wlast,
    input  logic s1_axi_wvalid, output logic s1_axi_wready,
    output logic [ID_WIDTH-1:0] s1_axi_bid, output logic [1:0] s1_axi_bresp, output logic s1_axi_bvalid, input logic s1_axi_bready,
    input  logic [ID_WIDTH-1:0] s1_axi_arid, input logic [ADDR_WIDTH-1:0] s1_axi_araddr, input logic [7:0] s1_axi_arlen,
    input  logic [2:0] s1_axi_arsize, input logic [1:0] s1_axi_arburst, input logic s1_axi_arlock,
    input  logic [3:0] s1_axi_arcache, input logic [2:0] s1_axi_arprot, input logic [3:0] s1_axi_arqos,
    input  logic s1_axi_arvalid, output logic s1_axi_arready,
    output logic [ID_WIDTH-1:0] s1_axi_rid, output logic [DATA_WIDTH-1:0] s1_axi_rdata, output logic [1:0] s1_axi_rresp,
    output logic s1_axi_rlast, output logic s1_axi_rvalid, input logic s1_axi_rready,
    // downstream master port
    output logic [ID_WIDTH-1:0] m_axi_awid, output logic [ADDR_WIDTH-1:0] m_axi_awaddr, output logic [7:0] m_axi_awlen,
    output logic [2:0] m_axi_awsize, output logic [1:0] m_axi_awburst, output logic m_axi_awlock,
    output logic [3:0] m_axi_awcache, output logic [2:0] m_axi_awprot, output logic [3:0] m_axi_awqos,
    output logic m_axi_awvalid, input logic m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata, output logic [DATA_WIDTH/8-1:0] m_axi_wstrb, output logic m_axi_wlast,
    output logic m_axi_wvalid, input logic m_axi_wready,
    input  logic [ID_WIDTH-1:0] m_axi_bid, input logic [1:0] m_axi_bresp, input logic m_axi_bvalid, output logic m_axi_bready,
    output logic [ID_WIDTH-1:0] m_axi_arid, output logic [ADDR_WIDTH-1:0] m_axi_araddr, output logic [7:0] m_axi_arlen,
    output logic [2:0] m_axi_arsize, output logic [1:0] m_axi_arburst, output logic m_axi_arlock,
    output logic [3:0] m_axi_arcache, output logic [2:0] m_axi_arprot, output logic [3:0] m_axi_arqos,
    output logic m_axi_arvalid, input logic m_axi_arready,
    input  logic [ID_WIDTH-1:0] m_axi_rid, input logic [DATA_WIDTH-1:0] m_axi_rdata, input logic [1:0] m_axi_rresp,
    input  logic m_axi_rlast, input logic m_axi_rvalid, output logic m_axi_rready,
    // grant status
    output logic [1:0] wr_grant_o,
    output logic [1:0] rd_grant_o
`ifdef SYS_MASTER_ARBITER_STATS_EN
    ,
    output logic [1:0][31:0] wr_grant_cnt_o,
    output logic [1:0][31:0] rd_grant_cnt_o
`endif
);

    localparam int AX_BITS = ID_WIDTH + ADDR_WIDTH + 25;
    localparam int W_BITS  = DATA_WIDTH + DATA_WIDTH / 8 + 1;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_AW = 2'd1, W_W = 2'd2, W_B = 2'd3} wr_state_e;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_R = 2'd2} rd_state_e;

    // Round-robin choice: a tie goes to the master that was not granted last.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        if (req0 && req1) begin
            rr_pick = ~last;
        end else if (req1) begin
            rr_pick = 1'b1;
        end else begin
            rr_pick = 1'b0;
        end
    endfunction

    wr_state_e wr_state_r, wr_state_nxt_s;
    rd_state_e rd_state_r, rd_state_nxt_s;
    logic [1:0] wr_grant_r, wr_grant_nxt_s, rd_grant_r, rd_grant_nxt_s;
    logic       wr_last_r, wr_last_nxt_s, rd_last_r, rd_last_nxt_s;
    logic       wr_pick_s, rd_pick_s;

    // Owner bit: 1 means s1 holds the channel (meaningful only outside IDLE).
    logic wr_own_s, rd_own_s;
    logic aw_sel_s, w_sel_s, b_sel_s, ar_sel_s, r_sel_s;
    logic [AX_BITS-1:0] s0_aw_s, s1_aw_s, s0_ar_s, s1_ar_s;
    logic [W_BITS-1:0]  s0_w_s, s1_w_s;

    assign wr_own_s = wr_grant_r[1];
    assign rd_own_s = rd_grant_r[1];
    assign aw_sel_s = (wr_state_r == W_AW);
    assign w_sel_s  = (wr_state_r == W_W);
    assign b_sel_s  = (wr_state_r == W_B);
    assign ar_sel_s = (rd_state_r == R_AR);
    assign r_sel_s  = (rd_state_r == R_R);

    assign wr_grant_o = wr_grant_r;
    assign rd_grant_o = rd_grant_r;

    assign s0_aw_s = {s0_axi_awid, s0_axi_awaddr, s0_axi_awlen, s0_axi_awsize, s0_axi_awburst,
                      s0_axi_awlock, s0_axi_awcache, s0_axi_awprot, s0_axi_awqos};
    assign s1_aw_s = {s1_axi_awid, s1_axi_awaddr, s1_axi_awlen, s1_axi_awsize, s1_axi_awburst,
                      s1_axi_awlock, s1_axi_awcache, s1_axi_awprot, s1_axi_awqos};
    assign s0_ar_s = {s0_axi_arid, s0_axi_araddr, s0_axi_arlen, s0_axi_arsize, s0_axi_arburst,
                      s0_axi_arlock, s0_axi_arcache, s0_axi_arprot, s0_axi_arqos};
    assign s1_ar_s = {s1_axi_arid, s1_axi_araddr, s1_axi_arlen, s1_axi_arsize, s1_axi_arburst,
                      s1_axi_arlock, s1_axi_arcache, s1_axi_arprot, s1_axi_arqos};
    assign s0_w_s  = {s0_axi_wdata, s0_axi_wstrb, s0_axi_wlast};
    assign s1_w_s  = {s1_axi_wdata, s1_axi_wstrb, s1_axi_wlast};

    // Request channels: only the owner in the matching phase reaches m_axi;
    // everything is zero otherwise, so early W from a non-owner stalls.
    assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
            m_axi_awcache, m_axi_awprot, m_axi_awqos} = aw_sel_s ? (wr_own_s ? s1_aw_s : s0_aw_s) : {AX_BITS{1'b0}};
    assign m_axi_awvalid  = aw_sel_s & (wr_own_s ? s1_axi_awvalid : s0_axi_awvalid);
    assign s0_axi_awready = aw_sel_s & ~wr_own_s & m_axi_awready;
    assign s1_axi_awready = aw_sel_s &  wr_own_s & m_axi_awready;

    assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast} = w_sel_s ? (wr_own_s ? s1_w_s : s0_w_s) : {W_BITS{1'b0}};
    assign m_axi_wvalid  = w_sel_s & (wr_own_s ? s1_axi_wvalid : s0_axi_wvalid);
    assign s0_axi_wready = w_sel_s & ~wr_own_s & m_axi_wready;
    assign s1_axi_wready = w_sel_s &  wr_own_s & m_axi_wready;

    assign {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
            m_axi_arcache, m_axi_arprot, m_axi_arqos} = ar_sel_s ? (rd_own_s ? s1_ar_s : s0_ar_s) : {AX_BITS{1'b0}};
    assign m_axi_arvalid  = ar_sel_s & (rd_own_s ? s1_axi_arvalid : s0_axi_arvalid);
    assign s0_axi_arready = ar_sel_s & ~rd_own_s & m_axi_arready;
    assign s1_axi_arready = ar_sel_s &  rd_own_s & m_axi_arready;

    // Response channels: routed to the owner only, zeros elsewhere.
    assign m_axi_bready  = b_sel_s & (wr_own_s ? s1_axi_bready : s0_axi_bready);
    assign s0_axi_bvalid = b_sel_s & ~wr_own_s & m_axi_bvalid;
    assign s1_axi_bvalid = b_sel_s &  wr_own_s & m_axi_bvalid;
    assign s0_axi_bid    = (b_sel_s & ~wr_own_s) ? m_axi_bid   : {ID_WIDTH{1'b0}};
    assign s1_axi_bid    = (b_sel_s &  wr_own_s) ? m_axi_bid   : {ID_WIDTH{1'b0}};
    assign s0_axi_bresp  = (b_sel_s & ~wr_own_s) ? m_axi_bresp : 2'b00;
    assign s1_axi_bresp  = (b_sel_s &  wr_own_s) ? m_axi_bresp : 2'b00;

    assign m_axi_rready  = r_sel_s & (rd_own_s ? s1_axi_rready : s0_axi_rready);
    assign s0_axi_rvalid = r_sel_s & ~rd_own_s & m_axi_rvalid;
    assign s1_axi_rvalid = r_sel_s &  rd_own_s & m_axi_rvalid;
    assign s0_axi_rid    = (r_sel_s & ~rd_own_s) ? m_axi_rid   : {ID_WIDTH{1'b0}};
    assign s1_axi_rid    = (r_sel_s &  rd_own_s) ? m_axi_rid   : {ID_WIDTH{1'b0}};
    assign s0_axi_rdata  = (r_sel_s & ~rd_own_s) ? m_axi_rdata : {DATA_WIDTH{1'b0}};
    assign s1_axi_rdata  = (r_sel_s &  rd_own_s) ? m_axi_rdata : {DATA_WIDTH{1'b0}};
    assign s0_axi_rresp  = (r_sel_s & ~rd_own_s) ? m_axi_rresp : 2'b00;
    assign s1_axi_rresp  = (r_sel_s &  rd_own_s) ? m_axi_rresp : 2'b00;
    assign s0_axi_rlast  = r_sel_s & ~rd_own_s & m_axi_rlast;
    assign s1_axi_rlast  = r_sel_s &  rd_own_s & m_axi_rlast;

    // Write FSM next state, grant and round-robin pointer
    always_comb begin
        wr_state_nxt_s = wr_state_r;
        wr_grant_nxt_s = wr_grant_r;
        wr_last_nxt_s  = wr_last_r;
        wr_pick_s      = rr_pick(s0_axi_awvalid, s1_axi_awvalid, wr_last_r);
        case (wr_state_r)
            W_IDLE: begin
                if (s0_axi_awvalid || s1_axi_awvalid) begin
                    wr_state_nxt_s = W_AW;
                    wr_grant_nxt_s = wr_pick_s ? 2'b10 : 2'b01;
                    wr_last_nxt_s  = wr_pick_s;
                end else begin
                    wr_state_nxt_s = W_IDLE;
                end
            end
            W_AW: begin
                if (m_axi_awvalid && m_axi_awready) begin
                    wr_state_nxt_s = W_W;
                end else begin
                    wr_state_nxt_s = W_AW;
                end
            end
            W_W: begin
                if (m_axi_wvalid && m_axi_wready && m_axi_wlast) begin
                    wr_state_nxt_s = W_B;
                end else begin
                    wr_state_nxt_s = W_W;
                end
            end
            W_B: begin
                if (m_axi_bvalid && m_axi_bready) begin
                    wr_state_nxt_s = W_IDLE;
                    wr_grant_nxt_s = 2'b00;
                end else begin
                    wr_state_nxt_s = W_B;
                end
            end
            default: begin
                wr_state_nxt_s = W_IDLE;
                wr_grant_nxt_s = 2'b00;
            end
        endcase
    end

    // Read FSM next state, grant and round-robin pointer
    always_comb begin
        rd_state_nxt_s = rd_state_r;
        rd_grant_nxt_s = rd_grant_r;
        rd_last_nxt_s  = rd_last_r;
        rd_pick_s      = rr_pick(s0_axi_arvalid, s1_axi_arvalid, rd_last_r);
        case (rd_state_r)
            R_IDLE: begin
                if (s0_axi_arvalid || s1_axi_arvalid) begin
                    rd_state_nxt_s = R_AR;
                    rd_grant_nxt_s = rd_pick_s ? 2'b10 : 2'b01;
                    rd_last_nxt_s  = rd_pick_s;
                end else begin
                    rd_state_nxt_s = R_IDLE;
                end
            end
            R_AR: begin
                if (m_axi_arvalid && m_axi_arready) begin
                    rd_state_nxt_s = R_R;
                end else begin
                    rd_state_nxt_s = R_AR;
                end
            end
            R_R: begin
                if (m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
                    rd_state_nxt_s = R_IDLE;
                    rd_grant_nxt_s = 2'b00;
                end else begin
                    rd_state_nxt_s = R_R;
                end
            end
            default: begin
                rd_state_nxt_s = R_IDLE;
                rd_grant_nxt_s = 2'b00;
            end
        endcase
    end

    // FSM state, grant and pointer registers; pointers reset to s1 so s0 wins the first tie
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_state_r <= W_IDLE;
            wr_grant_r <= 2'b00;
            wr_last_r  <= 1'b1;
            rd_state_r <= R_IDLE;
            rd_grant_r <= 2'b00;
            rd_last_r  <= 1'b1;
        end else begin
            wr_state_r <= wr_state_nxt_s;
            wr_grant_r <= wr_grant_nxt_s;
            wr_last_r  <= wr_last_nxt_s;
            rd_state_r <= rd_state_nxt_s;
            rd_grant_r <= rd_grant_nxt_s;
            rd_last_r  <= rd_last_nxt_s;
        end
    end

`ifdef SYS_MASTER_ARBITER_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating per-master grant counters, bumped on each IDLE exit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_grant_cnt_o <= {32'd0, 32'd0};
            rd_grant_cnt_o <= {32'd0, 32'd0};
        end else begin
            if ((wr_state_r == W_IDLE) && (s0_axi_awvalid || s1_axi_awvalid)) begin
                wr_grant_cnt_o[wr_pick_s] <= sat_inc(wr_grant_cnt_o[wr_pick_s]);
            end
            if ((rd_state_r == R_IDLE) && (s0_axi_arvalid || s1_axi_arvalid)) begin
                rd_grant_cnt_o[rd_pick_s] <= sat_inc(rd_grant_cnt_o[rd_pick_s]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sys_master_arbiter.sv
// Directed bench for sys_master_arbiter: reset state, single write, tie after
// reset, early W stall, read fairness, concurrent directions, reset mid-burst.
module tb_sys_master_arbiter;
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  s0_axi_awid, s1_axi_awid, m_axi_awid, s0_axi_arid, s1_axi_arid, m_axi_arid;
    logic [1:0]  s0_axi_bid, s1_axi_bid, m_axi_bid, s0_axi_rid, s1_axi_rid, m_axi_rid;
    logic [1:0]  s0_axi_awburst, s1_axi_awburst, m_axi_awburst, s0_axi_arburst, s1_axi_arburst, m_axi_arburst;
    logic [1:0]  s0_axi_bresp, s1_axi_bresp, m_axi_bresp, s0_axi_rresp, s1_axi_rresp, m_axi_rresp;
    logic [1:0]  wr_grant_o, rd_grant_o;
    logic [31:0] s0_axi_awaddr, s1_axi_awaddr, m_axi_awaddr, s0_axi_araddr, s1_axi_araddr, m_axi_araddr;
    logic [31:0] s0_axi_wdata, s1_axi_wdata, m_axi_wdata, s0_axi_rdata, s1_axi_rdata, m_axi_rdata;
    logic [7:0]  s0_axi_awlen, s1_axi_awlen, m_axi_awlen, s0_axi_arlen, s1_axi_arlen, m_axi_arlen;
    logic [2:0]  s0_axi_awsize, s1_axi_awsize, m_axi_awsize, s0_axi_arsize, s1_axi_arsize, m_axi_arsize;
    logic [2:0]  s0_axi_awprot, s1_axi_awprot, m_axi_awprot, s0_axi_arprot, s1_axi_arprot, m_axi_arprot;
    logic [3:0]  s0_axi_awcache, s1_axi_awcache, m_axi_awcache, s0_axi_arcache, s1_axi_arcache, m_axi_arcache;
    logic [3:0]  s0_axi_awqos, s1_axi_awqos, m_axi_awqos, s0_axi_arqos, s1_axi_arqos, m_axi_arqos;
    logic [3:0]  s0_axi_wstrb, s1_axi_wstrb, m_axi_wstrb;
    logic s0_axi_awlock, s1_axi_awlock, m_axi_awlock, s0_axi_arlock, s1_axi_arlock, m_axi_arlock;
    logic s0_axi_awvalid, s1_axi_awvalid, m_axi_awvalid, s0_axi_awready, s1_axi_awready, m_axi_awready;
    logic s0_axi_wlast, s1_axi_wlast, m_axi_wlast, s0_axi_wvalid, s1_axi_wvalid, m_axi_wvalid;
    logic s0_axi_wready, s1_axi_wready, m_axi_wready;
    logic s0_axi_bvalid, s1_axi_bvalid, m_axi_bvalid, s0_axi_bready, s1_axi_bready, m_axi_bready;
    logic s0_axi_arvalid, s1_axi_arvalid, m_axi_arvalid, s0_axi_arready, s1_axi_arready, m_axi_arready;
    logic s0_axi_rlast, s1_axi_rlast, m_axi_rlast, s0_axi_rvalid, s1_axi_rvalid, m_axi_rvalid;
    logic s0_axi_rready, s1_axi_rready, m_axi_rready;
`ifdef SYS_MASTER_ARBITER_STATS_EN
    logic [1:0][31:0] wr_grant_cnt_o, rd_grant_cnt_o;
`endif

    sys_master_arbiter dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .s0_axi_awid(s0_axi_awid), .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awlen(s0_axi_awlen), .s0_axi_awsize(s0_axi_awsize),
        .s0_axi_awburst(s0_axi_awburst), .s0_axi_awlock(s0_axi_awlock), .s0_axi_awcache(s0_axi_awcache), .s0_axi_awprot(s0_axi_awprot),
        .s0_axi_awqos(s0_axi_awqos), .s0_axi_awvalid(s0_axi_awvalid), .s0_axi_awready(s0_axi_awready),
        .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb), .s0_axi_wlast(s0_axi_wlast), .s0_axi_wvalid(s0_axi_wvalid), .s0_axi_wready(s0_axi_wready),
        .s0_axi_bid(s0_axi_bid), .s0_axi_bresp(s0_axi_bresp), .s0_axi_bvalid(s0_axi_bvalid), .s0_axi_bready(s0_axi_bready),
        .s0_axi_arid(s0_axi_arid), .s0_axi_araddr(s0_axi_araddr), .s0_axi_arlen(s0_axi_arlen), .s0_axi_arsize(s0_axi_arsize),
        .s0_axi_arburst(s0_axi_arburst), .s0_axi_arlock(s0_axi_arlock), .s0_axi_arcache(s0_axi_arcache), .s0_axi_arprot(s0_axi_arprot),
        .s0_axi_arqos(s0_axi_arqos), .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
        .s0_axi_rid(s0_axi_rid), .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp), .s0_axi_rlast(s0_axi_rlast),
        .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready),
        .s1_axi_awid(s1_axi_awid), .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_awlen(s1_axi_awlen), .s1_axi_awsize(s1_axi_awsize),
        .s1_axi_awburst(s1_axi_awburst), .s1_axi_awlock(s1_axi_awlock), .s1_axi_awcache(s1_axi_awcache), .s1_axi_awprot(s1_axi_awprot),
        .s1_axi_awqos(s1_axi_awqos), .s1_axi_awvalid(s1_axi_awvalid), .s1_axi_awready(s1_axi_awready),
        .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb), .s1_axi_wlast(s1_axi_wlast), .s1_axi_wvalid(s1_axi_wvalid), .s1_axi_wready(s1_axi_wready),
        .s1_axi_bid(s1_axi_bid), .s1_axi_bresp(s1_axi_bresp), .s1_axi_bvalid(s1_axi_bvalid), .s1_axi_bready(s1_axi_bready),
        .s1_axi_arid(s1_axi_arid), .s1_axi_araddr(s1_axi_araddr), .s1_axi_arlen(s1_axi_arlen), .s1_axi_arsize(s1_axi_arsize),
        .s1_axi_arburst(s1_axi_arburst), .s1_axi_arlock(s1_axi_arlock), .s1_axi_arcache(s1_axi_arcache), .s1_axi_arprot(s1_axi_arprot),
        .s1_axi_arqos(s1_axi_arqos), .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
        .s1_axi_rid(s1_axi_rid), .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp), .s1_axi_rlast(s1_axi_rlast),
        .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awqos(m_axi_awqos), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arqos(m_axi_arqos), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .wr_grant_o(wr_grant_o), .rd_grant_o(rd_grant_o)
`ifdef SYS_MASTER_ARBITER_STATS_EN
        , .wr_grant_cnt_o(wr_grant_cnt_o), .rd_grant_cnt_o(rd_grant_cnt_o)
`endif
    );

    int total = 0;
    int bad   = 0;
    logic [1:0] seq [6];
    int n;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        {s0_axi_awid, s0_axi_awaddr, s0_axi_awlen, s0_axi_awsize, s0_axi_awburst, s0_axi_awlock,
         s0_axi_awcache, s0_axi_awprot, s0_axi_awqos, s0_axi_awvalid} = 58'd0;
        {s1_axi_awid, s1_axi_awaddr, s1_axi_awlen, s1_axi_awsize, s1_axi_awburst, s1_axi_awlock,
         s1_axi_awcache, s1_axi_awprot, s1_axi_awqos, s1_axi_awvalid} = 58'd0;
        {s0_axi_arid, s0_axi_araddr, s0_axi_arlen, s0_axi_arsize, s0_axi_arburst, s0_axi_arlock,
         s0_axi_arcache, s0_axi_arprot, s0_axi_arqos, s0_axi_arvalid} = 58'd0;
        {s1_axi_arid, s1_axi_araddr, s1_axi_arlen, s1_axi_arsize, s1_axi_arburst, s1_axi_arlock,
         s1_axi_arcache, s1_axi_arprot, s1_axi_arqos, s1_axi_arvalid} = 58'd0;
        {s0_axi_wdata, s0_axi_wstrb, s0_axi_wlast, s0_axi_wvalid, s0_axi_bready, s0_axi_rready} = 40'd0;
        {s1_axi_wdata, s1_axi_wstrb, s1_axi_wlast, s1_axi_wvalid, s1_axi_bready, s1_axi_rready} = 40'd0;
        {m_axi_awready, m_axi_wready, m_axi_arready} = 3'd0;
        {m_axi_bid, m_axi_bresp, m_axi_bvalid} = 5'd0;
        {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid} = 38'd0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_ni = 1'b1;
        settle();
    endtask

    initial begin
        clear_inputs();
        #2;
        // reset state
        chk("rst_wr_grant", 64'(wr_grant_o), 64'd0);
        chk("rst_rd_grant", 64'(rd_grant_o), 64'd0);
        chk("rst_m_valid_ready", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 64'd0);
        chk("rst_s_ready_resp", 64'({s0_axi_awready, s1_axi_awready, s0_axi_wready, s1_axi_wready, s0_axi_arready,
                                     s1_axi_arready, s0_axi_bvalid, s1_axi_bvalid, s0_axi_rvalid, s1_axi_rvalid}), 64'd0);
`ifdef SYS_MASTER_ARBITER_STATS_EN
        chk("rst_cnt", 64'(wr_grant_cnt_o[0] | wr_grant_cnt_o[1] | rd_grant_cnt_o[0] | rd_grant_cnt_o[1]), 64'd0);
`endif
        tick();
        tick();
        rst_ni = 1'b1;
        settle();

        // single-master write from s0
        s0_axi_awvalid = 1'b1; s0_axi_awaddr = 32'h1000_0000; s0_axi_awid = 2'd1; s0_axi_awlen = 8'd0;
        settle();
        chk("t1_awvalid_idle", 64'(m_axi_awvalid), 64'd0);
        tick();
        chk("t1_awvalid_lat1", 64'(m_axi_awvalid), 64'd1);
        chk("t1_awaddr", 64'(m_axi_awaddr), 64'h1000_0000);
        chk("t1_awid", 64'(m_axi_awid), 64'd1);
        chk("t1_grant_aw", 64'(wr_grant_o), 64'd1);
        chk("t1_awready_hold", 64'(s0_axi_awready), 64'd0);
        m_axi_awready = 1'b1;
        settle();
        chk("t1_awready", 64'(s0_axi_awready), 64'd1);
        tick();
        s0_axi_awvalid = 1'b0;
        s0_axi_wvalid = 1'b1; s0_axi_wdata = 32'hDEAD_BEEF; s0_axi_wstrb = 4'hF; s0_axi_wlast = 1'b1;
        m_axi_wready = 1'b1;
        settle();
        chk("t1_wdata", 64'({m_axi_wvalid, m_axi_wstrb, m_axi_wdata}), 64'h1_F_DEAD_BEEF);
        chk("t1_grant_w", 64'(wr_grant_o), 64'd1);
        tick();
        s0_axi_wvalid = 1'b0;
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'd0; m_axi_bid = 2'd1;
        s0_axi_bready = 1'b1; s1_axi_bready = 1'b1;
        settle();
        chk("t1_s0_b", 64'({s0_axi_bvalid, s0_axi_bid, s0_axi_bresp}), 64'b1_01_00);
        chk("t1_s1_bvalid", 64'(s1_axi_bvalid), 64'd0);
        chk("t1_bready", 64'(m_axi_bready), 64'd1);
        chk("t1_grant_b", 64'(wr_grant_o), 64'd1);
        tick();
        m_axi_bvalid = 1'b0;
        settle();
        chk("t1_grant_end", 64'(wr_grant_o), 64'd0);

        // simultaneous len=3 writes right after reset: s0 first, then s1
        do_reset();
        s0_axi_awvalid = 1'b1; s0_axi_awaddr = 32'h0000_0100; s0_axi_awlen = 8'd3;
        s1_axi_awvalid = 1'b1; s1_axi_awaddr = 32'h0000_0200; s1_axi_awlen = 8'd3;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; s0_axi_bready = 1'b1; s1_axi_bready = 1'b1;
        tick();
        chk("t2_first_grant", 64'(wr_grant_o), 64'd1);
        chk("t2_first_addr", 64'(m_axi_awaddr), 64'h100);
        tick();
        s0_axi_awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s0_axi_wvalid = 1'b1; s0_axi_wdata = 32'(i); s0_axi_wlast = (i == 3);
            settle();
            chk("t2_s0_wlast", 64'({m_axi_wvalid, m_axi_wlast}), 64'({1'b1, (i == 3)}));
            chk("t2_s1_awready", 64'(s1_axi_awready), 64'd0);
            tick();
        end
        s0_axi_wvalid = 1'b0;
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;
        settle();
        chk("t2_idle_gap", 64'(m_axi_awvalid), 64'd0);
        tick();
        chk("t2_second_grant", 64'(wr_grant_o), 64'd2);
        chk("t2_second_addr", 64'(m_axi_awaddr), 64'h200);
        tick();
        s1_axi_awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s1_axi_wvalid = 1'b1; s1_axi_wdata = 32'(i + 16); s1_axi_wlast = (i == 3);
            tick();
        end
        s1_axi_wvalid = 1'b0;
        m_axi_bvalid = 1'b1;
        settle();
        chk("t2_s1_bvalid", 64'({s1_axi_bvalid, s0_axi_bvalid}), 64'b10);
        tick();
        m_axi_bvalid = 1'b0;

        // early W from s1 while s0 owns the write channel
        s0_axi_awvalid = 1'b1; s0_axi_awlen = 8'd0;
        tick();
        s1_axi_wvalid = 1'b1; s1_axi_wdata = 32'h0000_0BAD; s1_axi_wlast = 1'b1;
        settle();
        chk("t3_early_wready_aw", 64'({s1_axi_wready, m_axi_wvalid}), 64'd0);
        tick();
        s0_axi_awvalid = 1'b0;
        settle();
        chk("t3_early_wready_w0", 64'({s1_axi_wready, m_axi_wvalid}), 64'd0);
        s1_axi_awvalid = 1'b1; s1_axi_awlen = 8'd0;
        s0_axi_wvalid = 1'b1; s0_axi_wdata = 32'h0000_0055; s0_axi_wlast = 1'b1;
        settle();
        chk("t3_s0_wdata", 64'(m_axi_wdata), 64'h55);
        chk("t3_early_wready_w1", 64'(s1_axi_wready), 64'd0);
        tick();
        s0_axi_wvalid = 1'b0;
        m_axi_bvalid = 1'b1;
        settle();
        chk("t3_early_wready_b", 64'(s1_axi_wready), 64'd0);
        tick();
        m_axi_bvalid = 1'b0;
        settle();
        chk("t3_early_wready_idle", 64'(s1_axi_wready), 64'd0);
        tick();
        chk("t3_s1_grant", 64'(wr_grant_o), 64'd2);
        chk("t3_early_wready_aw2", 64'(s1_axi_wready), 64'd0);
        tick();
        s1_axi_awvalid = 1'b0;
        settle();
        chk("t3_s1_wready", 64'({s1_axi_wready, m_axi_wvalid}), 64'b11);
        chk("t3_s1_wdata", 64'(m_axi_wdata), 64'hBAD);
        tick();
        s1_axi_wvalid = 1'b0;
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;

        // read fairness: both masters keep requesting single-beat reads
        s0_axi_arvalid = 1'b1; s0_axi_arid = 2'd1; s1_axi_arvalid = 1'b1; s1_axi_arid = 2'd2;
        m_axi_arready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
        s0_axi_rready = 1'b1; s1_axi_rready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            settle();
            chk("t4_rd_grant_not_11", 64'(rd_grant_o == 2'b11), 64'd0);
            if (m_axi_arvalid && m_axi_arready) begin
                seq[n] = m_axi_arid;
                n++;
            end
            tick();
        end
        s0_axi_arvalid = 1'b0; s1_axi_arvalid = 1'b0;
        chk("t4_count", 64'(n), 64'd6);
        for (int k = 0; k < 6; k++) begin
            chk("t4_order", 64'(seq[k]), (k % 2 == 0) ? 64'd1 : 64'd2);
        end
        tick();
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;

        // concurrent: s0 reads len=7 while s1 writes len=1
        s0_axi_arvalid = 1'b1; s0_axi_arid = 2'd1; s0_axi_arlen = 8'd7;
        s1_axi_awvalid = 1'b1; s1_axi_awid = 2'd2; s1_axi_awlen = 8'd1;
        tick();
        chk("t5_both_grants", 64'({rd_grant_o, wr_grant_o}), 64'b01_10);
        tick();
        s0_axi_arvalid = 1'b0; s1_axi_awvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_axi_rvalid = 1'b1; m_axi_rid = 2'd1; m_axi_rdata = 32'(i + 100); m_axi_rlast = (i == 7);
            s1_axi_wvalid = (i < 2); s1_axi_wlast = (i == 1);
            m_axi_bvalid = (i == 2); m_axi_bid = 2'd2;
            settle();
            chk("t5_s0_r", 64'({s0_axi_rvalid, s0_axi_rid, s0_axi_rlast, s1_axi_rvalid}), 64'({1'b1, 2'd1, (i == 7), 1'b0}));
            chk("t5_s0_rdata", 64'(s0_axi_rdata), 64'(i + 100));
            if (i == 2) begin
                chk("t5_s1_b", 64'({s1_axi_bvalid, s1_axi_bid, s0_axi_bvalid}), 64'b1_10_0);
            end
            tick();
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_bvalid = 1'b0; s1_axi_wvalid = 1'b0;
        settle();
        chk("t5_grants_end", 64'({rd_grant_o, wr_grant_o}), 64'd0);

        // reset asserted during beat 2 of a len=3 write
        s0_axi_awvalid = 1'b1; s0_axi_awaddr = 32'h0000_0300; s0_axi_awlen = 8'd3;
        tick();
        tick();
        s0_axi_awvalid = 1'b0;
        s0_axi_wvalid = 1'b1; s0_axi_wdata = 32'd0; s0_axi_wlast = 1'b0;
        tick();
        s0_axi_wdata = 32'd1;
        settle();
        chk("t6_beat2_live", 64'({m_axi_wvalid, wr_grant_o}), 64'b1_01);
        rst_ni = 1'b0;
        settle();
        chk("t6_async_clear", 64'({m_axi_wvalid, s0_axi_wready, wr_grant_o, m_axi_awvalid, m_axi_bready}), 64'd0);
        clear_inputs();
        tick();
        rst_ni = 1'b1;
        settle();
`ifdef SYS_MASTER_ARBITER_STATS_EN
        chk("t6_cnt_zero", 64'(wr_grant_cnt_o[0] | wr_grant_cnt_o[1] | rd_grant_cnt_o[0] | rd_grant_cnt_o[1]), 64'd0);
`endif
        s0_axi_awvalid = 1'b1; s0_axi_awaddr = 32'h0000_0400;
        s1_axi_awvalid = 1'b1; s1_axi_awaddr = 32'h0000_0500;
        tick();
        chk("t6_tie_grant", 64'(wr_grant_o), 64'd1);
        chk("t6_tie_addr", 64'(m_axi_awaddr), 64'h400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
